// File: rtl/rv_pkg.sv
// Shared RV32I datapath constants: register width, register-index width, x0 index.
package rv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage : rv_pkg

// File: rtl/register_file_if.sv
// Register-file bus: one write port and two read ports.
interface register_file_if
    import rv_pkg::*;
#(
    parameter int unsigned N      = XLEN,
    parameter int unsigned ADDR_W = REG_ADDR_W
);

    logic              we;
    logic [ADDR_W-1:0] rd_addr;
    logic [N-1:0]      rd_data;
    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic [N-1:0]      rs1_data;
    logic [N-1:0]      rs2_data;

    modport master (
        output we, rd_addr, rd_data, rs1_addr, rs2_addr,
        input  rs1_data, rs2_data
    );

    modport slave (
        input  we, rd_addr, rd_data, rs1_addr, rs2_addr,
        output rs1_data, rs2_data
    );

endinterface : register_file_if

// File: rtl/rf_read_port.sv
// One combinational read port: entry select, x0 force-zero, write-first bypass.
module rf_read_port
    import rv_pkg::*;
#(
    parameter int unsigned N      = XLEN,
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input  logic [(2**ADDR_W)-1:0][N-1:0] regs,
    input  logic [ADDR_W-1:0]             addr,
    input  logic                          byp_en,
    input  logic [ADDR_W-1:0]             byp_addr,
    input  logic [N-1:0]                  byp_data,
    output logic [N-1:0]                  data
);

    // x0 wins over the bypass, the bypass wins over stored contents.
    always_comb begin
        data = regs[addr];
        if (addr == ADDR_W'(REG_ZERO)) begin
            data = '0;
        end else if (byp_en && (byp_addr == addr)) begin
            data = byp_data;
        end
    end

endmodule : rf_read_port

// File: rtl/register_file.sv
// RV32I integer register file: 32 x N storage, one synchronous write, two bypassed reads.
module register_file
    import rv_pkg::*;
#(
    parameter int unsigned N      = XLEN,
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input  logic            clk,
    input  logic            rst,
    register_file_if.slave  bus
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    // Entry 0 has no storage; the read view splices in a constant zero.
    logic [DEPTH-1:1][N-1:0] regs;
    logic [DEPTH-1:0][N-1:0] view;
    logic                    byp_en;

    // Synchronous clear dominates; otherwise full-width write to nonzero index.
    always_ff @(posedge clk) begin
        if (!rst) begin
            regs <= '0;
        end else if (bus.we && (bus.rd_addr != ADDR_W'(REG_ZERO))) begin
            regs[bus.rd_addr] <= bus.rd_data;
        end
    end

    assign view   = {regs, N'(0)};
    // A write held off by reset must not leak through the bypass either.
    assign byp_en = bus.we & rst;

    rf_read_port #(.N(N), .ADDR_W(ADDR_W)) u_rs1 (
        .regs     (view),
        .addr     (bus.rs1_addr),
        .byp_en   (byp_en),
        .byp_addr (bus.rd_addr),
        .byp_data (bus.rd_data),
        .data     (bus.rs1_data)
    );

    rf_read_port #(.N(N), .ADDR_W(ADDR_W)) u_rs2 (
        .regs     (view),
        .addr     (bus.rs2_addr),
        .byp_en   (byp_en),
        .byp_addr (bus.rd_addr),
        .byp_data (bus.rd_data),
        .data     (bus.rs2_data)
    );

endmodule : register_file

// File: tb/tb_register_file.sv
// Directed, table-driven bench for register_file.
module tb_register_file;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  rd_addr;
        logic [31:0] rd_data;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    logic clk;
    logic rst;
    int   applied;
    int   miscompares;

    register_file_if #(.N(32), .ADDR_W(5)) bus ();

    register_file #(.N(32), .ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [4:0] rda, input logic [31:0] rdd,
                         input logic [4:0] a1, input logic [4:0] a2);
        rst          = r;
        bus.we       = w;
        bus.rd_addr  = rda;
        bus.rd_data  = rdd;
        bus.rs1_addr = a1;
        bus.rs2_addr = a2;
    endtask

    // Drive one cycle's inputs, check the combinational reads before the edge, then clock.
    task automatic apply(input vec_t v, input string tag);
        drive(v.rst, v.we, v.rd_addr, v.rd_data, v.rs1_addr, v.rs2_addr);
        #1;
        check({tag, ".rs1"}, bus.rs1_data, v.exp1);
        check({tag, ".rs2"}, bus.rs2_data, v.exp2);
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[16];
    vec_t v;

    initial begin
        applied     = 0;
        miscompares = 0;

        //             rst   we    rd     rd_data        rs1    rs2    exp1           exp2
        tbl[0]  = '{1'b1, 1'b1, 5'd7,  32'h1234_5678, 5'd7,  5'd31, 32'h1234_5678, 32'h0000_0000};
        tbl[1]  = '{1'b1, 1'b1, 5'd31, 32'hDEAD_BEEF, 5'd7,  5'd31, 32'h1234_5678, 32'hDEAD_BEEF};
        tbl[2]  = '{1'b1, 1'b0, 5'd0,  32'h0000_0000, 5'd7,  5'd31, 32'h1234_5678, 32'hDEAD_BEEF};
        tbl[3]  = '{1'b1, 1'b1, 5'd0,  32'hA5A5_A5A5, 5'd0,  5'd0,  32'h0000_0000, 32'h0000_0000};
        tbl[4]  = '{1'b1, 1'b0, 5'd0,  32'hA5A5_A5A5, 5'd0,  5'd0,  32'h0000_0000, 32'h0000_0000};
        tbl[5]  = '{1'b1, 1'b1, 5'd3,  32'h0000_0011, 5'd3,  5'd4,  32'h0000_0011, 32'h0000_0000};
        tbl[6]  = '{1'b1, 1'b1, 5'd4,  32'h0000_0044, 5'd3,  5'd4,  32'h0000_0011, 32'h0000_0044};
        tbl[7]  = '{1'b1, 1'b1, 5'd3,  32'h0000_0022, 5'd3,  5'd4,  32'h0000_0022, 32'h0000_0044};
        tbl[8]  = '{1'b1, 1'b0, 5'd3,  32'h0000_0099, 5'd3,  5'd4,  32'h0000_0022, 32'h0000_0044};
        tbl[9]  = '{1'b1, 1'b1, 5'd7,  32'hCAFE_0001, 5'd7,  5'd7,  32'hCAFE_0001, 32'hCAFE_0001};
        tbl[10] = '{1'b1, 1'b0, 5'd0,  32'h0000_0000, 5'd7,  5'd7,  32'hCAFE_0001, 32'hCAFE_0001};
        tbl[11] = '{1'b1, 1'b0, 5'd0,  32'h0000_0000, 5'd31, 5'd3,  32'hDEAD_BEEF, 32'h0000_0022};
        tbl[12] = '{1'b1, 1'b0, 5'd31, 32'hFFFF_FFFF, 5'd31, 5'd31, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        tbl[13] = '{1'b0, 1'b1, 5'd3,  32'h0000_0077, 5'd3,  5'd0,  32'h0000_0022, 32'h0000_0000};
        tbl[14] = '{1'b1, 1'b0, 5'd0,  32'h0000_0000, 5'd3,  5'd31, 32'h0000_0000, 32'h0000_0000};
        tbl[15] = '{1'b1, 1'b1, 5'd1,  32'h0000_0001, 5'd1,  5'd2,  32'h0000_0001, 32'h0000_0000};

        // Power-up reset: two cycles of rst=0 with a competing write to x5.
        drive(1'b0, 1'b1, 5'd5, 32'hFFFF_FFFF, 5'd0, 5'd0);
        #1;
        check("reset_x0_rs1", bus.rs1_data, 32'h0);
        check("reset_x0_rs2", bus.rs2_data, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int a = 0; a < 32; a++) begin
            drive(1'b1, 1'b0, 5'd0, 32'h0, 5'(a), 5'd5);
            #1;
            check($sformatf("post_reset_rs1[%0d]", a), bus.rs1_data, 32'h0);
            check($sformatf("post_reset_x5_rs2[%0d]", a), bus.rs2_data, 32'h0);
        end
        @(posedge clk);
        #1;

        // Main directed table.
        for (int i = 0; i < 16; i++) begin
            v = tbl[i];
            apply(v, $sformatf("vec%0d", i));
        end

        // Reset mid-stream: fill x1..x31 with their own index, verify, then pulse reset.
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 1'b1, 5'(i), 32'(i), 5'd0, 5'd0);
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
            #1;
            check($sformatf("fill_rs1[%0d]", i), bus.rs1_data, 32'(i));
            check($sformatf("fill_rs2[%0d]", 31 - i), bus.rs2_data, 32'(31 - i));
        end
        drive(1'b0, 1'b1, 5'd9, 32'h0000_0099, 5'd9, 5'd0);
        #1;
        check("mid_reset_no_bypass", bus.rs1_data, 32'h0000_0009);
        check("mid_reset_x0", bus.rs2_data, 32'h0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'b0, 5'd9, 32'h0000_0099, 5'(i), 5'd9);
            #1;
            check($sformatf("cleared_rs1[%0d]", i), bus.rs1_data, 32'h0);
            check("cleared_x9", bus.rs2_data, 32'h0);
        end

        // First edge after reset release accepts a write again.
        drive(1'b1, 1'b1, 5'd9, 32'h0000_005A, 5'd1, 5'd2);
        #1;
        check("post_mid_reset_x1", bus.rs1_data, 32'h0);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
        #1;
        check("rewrite_x9_rs1", bus.rs1_data, 32'h0000_005A);
        check("rewrite_x9_rs2", bus.rs2_data, 32'h0000_005A);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule : tb_register_file

// File: doc/register_file.md
# register_file

Integer register file for the RV32I single-cycle datapath: 32 architectural registers of N bits, one synchronous write port, two combinational read ports. It is the read-side counterpart to the datapath's loadable N-bit registers. The decoder supplies rs1/rs2/rd. Operand values feed the ALU and store-data path, and the writeback mux drives the write port. Register x0 reads as zero at all times, and a same-cycle write to a register being read is bypassed to the read port.

## Interface
Parameters:
- N, 32, register width (XLEN)
- ADDR_W, 5, register-index width; depth is 2**ADDR_W

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-low (asserted when 0)
- we  input  1  write enable (RegWrite)
- rd_addr  input  ADDR_W  write index
- rd_data  input  N  write data
- rs1_addr  input  ADDR_W  read port 1 index
- rs2_addr  input  ADDR_W  read port 2 index
- rs1_data  output  N  read port 1 value
- rs2_data  output  N  read port 2 value

## Operation
- Storage: 2**ADDR_W entries of N bits. Entry 0 has no storage and is constant zero.
- Write: on a rising clk edge with rst=1 and we=1 and rd_addr≠0, mem[rd_addr] ← rd_data. If we=0 or rd_addr=0, no state change.
- Read (combinational), per port p ∈ {rs1, rs2}:
  - p_addr=0 → 0, regardless of we, rd_addr or rd_data.
  - else if we=1, rst=1 and rd_addr=p_addr → rd_data (write-first bypass).
  - else → mem[p_addr].
- Both ports may address the same register; both return an identical value.
- Reset: on a rising edge with rst=0, every entry clears to 0, and any coincident write is discarded.
  - While rst=0, the bypass is disabled, so reads return stored contents (not rd_data).
- Writes are to full width only. There are no partial/byte writes.
- The block has no handshake: write is accepted every cycle we=1. Read data is valid whenever the addresses are stable.

## Timing
- Write latency: 1 cycle. The value is visible through storage from the cycle after the edge, and through the bypass in the same cycle.
- Read latency: 0 cycles, combinational from rs*_addr, we, rd_addr, rd_data.
- Reset values: all entries 0, so rs1_data = rs2_data = 0 for every address in the cycle after reset is released.
- Reset mid-operation: a write presented in the same cycle as rst=0 is lost. The first write that can take effect is on the first edge with rst=1.
- Simultaneous events:
  - Write and read of the same nonzero index: the read returns the new value.
  - Write to x0 concurrent with a read of x0: the read returns 0.
- Critical path: rs*_addr → 32:1 mux → bypass mux → output. There is no internal registering of outputs.

## Structure
- Shared package rv_pkg holds XLEN=32, REG_ADDR_W=5, REG_ZERO=5'd0; parameters default from it.
- Sub-module rf_read_port (address decode, 32:1 select, x0 force-zero, bypass compare) is instantiated twice, once per read port.
- The storage array and write logic stay in the top of register_file.

## Test plan
- Reset: hold rst=0 for 2 cycles with we=1, rd_addr=5, rd_data=0xFFFF_FFFF. Release, then sweep rs1_addr 0..31 → rs1_data = 0 for all; mem[5] stays 0.
- Write/readback: write 0x1234_5678 to x7, then 0xDEAD_BEEF to x31. Next cycles rs1=7, rs2=31 → rs1_data = 0x1234_5678, rs2_data = 0xDEAD_BEEF.
- x0 immunity: we=1, rd_addr=0, rd_data=0xA5A5_A5A5 with rs1=rs2=0 → both outputs 0 in that cycle and the following cycle.
- Bypass: x3 holds 0x0000_0011; set we=1, rd_addr=3, rd_data=0x0000_0022, rs1=3, rs2=4 → rs1_data = 0x22 in the same cycle, rs2_data = mem[4]. After the edge, rs1_data is still 0x22 with we=0.
- Dual same-address read: rs1=rs2=7 after writing 0xCAFE_0001 → both outputs 0xCAFE_0001. we=0 cycles leave all contents unchanged.
- Reset mid-stream:
  - Fill x1..x31 with the value i.
  - Assert rst=0 for 1 cycle with we=1, rd_addr=9, rd_data=0x99.
  - Expect all entries 0 afterwards, and during the reset cycle rs1=9 → rs1_data = 0x9 (stored value, bypass disabled).
